// File: rtl/rpm_channel_scheduler_if.sv
// Bundles the scheduler's control, tach-mux, shared-counter and result signals.
// The master modport is the scheduler side; the slave modport is its environment.
interface rpm_channel_scheduler_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned RPM_WIDTH = 16
);
    logic                 run;
    logic [NUM_CH-1:0]    ch_enable;
    logic [NUM_CH-1:0]    pulse_in;
    logic                 pulse_mux;
    logic [CH_W-1:0]      ch_sel;
    logic                 cnt_clear;
    logic                 cnt_gate;
    logic [RPM_WIDTH-1:0] cnt_value;
    logic                 cnt_sat;
    logic                 busy;
    logic                 result_valid;
    logic [CH_W-1:0]      result_ch;
    logic [RPM_WIDTH-1:0] result_count;
    logic                 result_sat;

    modport master (
        input  run, ch_enable, pulse_in, cnt_value, cnt_sat,
        output pulse_mux, ch_sel, cnt_clear, cnt_gate, busy,
               result_valid, result_ch, result_count, result_sat
    );

    modport slave (
        output run, ch_enable, pulse_in, cnt_value, cnt_sat,
        input  pulse_mux, ch_sel, cnt_clear, cnt_gate, busy,
               result_valid, result_ch, result_count, result_sat
    );
endinterface

// File: rtl/rpm_channel_scheduler.sv
// Round-robin scheduler sharing one pulse counter across NUM_CH tach inputs:
// select -> settle -> gate window -> capture a tagged count.
module rpm_channel_scheduler #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CH_W          = 2,
    parameter int unsigned RPM_WIDTH     = 16,
    parameter int unsigned WINDOW_CYCLES = 12_500_000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input logic                        clk,
    input logic                        rst,
    rpm_channel_scheduler_if.master    bus
);
    localparam int unsigned LAST_CH = NUM_CH - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_GATE,
        ST_CAPTURE
    } state_e;

    state_e               state_q;
    logic [CH_W-1:0]      last_ch_q;
    logic [CH_W-1:0]      ch_sel_q;
    logic [31:0]          settle_cnt_q;
    logic [31:0]          win_cnt_q;
    logic                 busy_q;
    logic                 cnt_clear_q;
    logic                 cnt_gate_q;
    logic                 result_valid_q;
    logic [CH_W-1:0]      result_ch_q;
    logic [RPM_WIDTH-1:0] result_count_q;
    logic                 result_sat_q;

    logic                 hit_c;
    logic [CH_W-1:0]      win_c;

    // First enabled channel after last_ch, wrapping modulo NUM_CH.
    always_comb begin
        logic [CH_W-1:0] idx;
        hit_c = 1'b0;
        win_c = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((32'(last_ch_q) + 32'd1 + i) % NUM_CH);
            if (!hit_c && bus.ch_enable[idx]) begin
                hit_c = 1'b1;
                win_c = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_ch_q      <= CH_W'(LAST_CH);
            ch_sel_q       <= '0;
            settle_cnt_q   <= '0;
            win_cnt_q      <= '0;
            busy_q         <= 1'b0;
            cnt_clear_q    <= 1'b0;
            cnt_gate_q     <= 1'b0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_count_q <= '0;
            result_sat_q   <= 1'b0;
        end else begin
            cnt_clear_q    <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.run) begin
                        state_q <= ST_SELECT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (!bus.run) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (hit_c) begin
                        state_q      <= ST_SETTLE;
                        ch_sel_q     <= win_c;
                        last_ch_q    <= win_c;
                        cnt_clear_q  <= 1'b1;
                        settle_cnt_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_CYCLES - 1) begin
                        state_q    <= ST_GATE;
                        cnt_gate_q <= 1'b1;
                        win_cnt_q  <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 32'd1;
                    end
                end
                ST_GATE: begin
                    if (win_cnt_q == WINDOW_CYCLES - 1) begin
                        state_q    <= ST_CAPTURE;
                        cnt_gate_q <= 1'b0;
                    end else begin
                        win_cnt_q <= win_cnt_q + 32'd1;
                    end
                end
                ST_CAPTURE: begin
                    // Counter output already reflects the final gate cycle here.
                    result_count_q <= bus.cnt_value;
                    result_sat_q   <= bus.cnt_sat;
                    result_ch_q    <= ch_sel_q;
                    result_valid_q <= 1'b1;
                    state_q        <= ST_SELECT;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    cnt_gate_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse_mux    = bus.pulse_in[ch_sel_q];
    assign bus.ch_sel       = ch_sel_q;
    assign bus.cnt_clear    = cnt_clear_q;
    assign bus.cnt_gate     = cnt_gate_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_ch    = result_ch_q;
    assign bus.result_count = result_count_q;
    assign bus.result_sat   = result_sat_q;
endmodule

// File: tb/tb_rpm_channel_scheduler.sv
// Directed bench for rpm_channel_scheduler with a rising-edge pulse counter model.
module tb_rpm_channel_scheduler;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned RPM_W  = 16;
    localparam int unsigned W      = 100;
    localparam int unsigned S      = 4;

    logic clk = 1'b0;
    logic rst;
    logic sat_force;
    logic [RPM_W-1:0] model_cnt;
    logic prev_mux;

    int checks   = 0;
    int failures = 0;

    rpm_channel_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .RPM_WIDTH(RPM_W)) bus ();

    rpm_channel_scheduler #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .RPM_WIDTH(RPM_W),
        .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Shared counter: counts gated rising edges of pulse_mux, one-cycle latency.
    always @(posedge clk) begin
        if (rst) begin
            model_cnt <= '0;
            prev_mux  <= 1'b0;
        end else begin
            prev_mux <= bus.pulse_mux;
            if (bus.cnt_clear)
                model_cnt <= '0;
            else if (bus.cnt_gate && bus.pulse_mux && !prev_mux)
                model_cnt <= model_cnt + 16'd1;
        end
    end

    assign bus.cnt_value = sat_force ? 16'hFFFF : model_cnt;
    assign bus.cnt_sat   = sat_force;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.ch_enable = '0;
        bus.pulse_in  = '0;
        sat_force     = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // which: 0 = cnt_gate, 1 = cnt_clear, 2 = result_valid
    task automatic wait_for(input int which, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if ((which == 0 && bus.cnt_gate) || (which == 1 && bus.cnt_clear) ||
                (which == 2 && bus.result_valid)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {bus.busy, bus.ch_sel, bus.cnt_clear, bus.cnt_gate, bus.result_valid,
                bus.result_ch, bus.result_count, bus.result_sat};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_vec() !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", out_vec());
        end
    endtask

    task automatic test_reset_mid_gate();
        bit ok;
        int rv_seen;
        do_reset();
        bus.ch_enable = 4'b0110;
        bus.run       = 1'b1;
        wait_for(0, 50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rmg_gate_timeout: got 0 expected 1"); end
        step(50);
        rst = 1'b1;
        step(1);
        checks++;
        if (out_vec() !== 32'h0) begin
            failures++;
            $display("FAIL rmg_outputs: got %h expected 0", out_vec());
        end
        bus.ch_enable = 4'b1111;
        step(1);
        rst     = 1'b0;
        rv_seen = 0;
        ok      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.result_valid) rv_seen++;
            if (bus.cnt_clear) begin ok = 1'b1; break; end
            step(1);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rmg_clear_timeout: got 0 expected 1"); end
        checks++;
        if (bus.ch_sel !== 2'd0) begin
            failures++;
            $display("FAIL rmg_first_ch: got %0d expected 0", bus.ch_sel);
        end
        checks++;
        if (rv_seen != 0) begin
            failures++;
            $display("FAIL rmg_no_result: got %0d expected 0", rv_seen);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int b2b;
        bit prev_rv;
        int ch_q[6];
        int cyc_q[6];
        int exp_ch[6];
        exp_ch = '{0, 1, 3, 0, 1, 3};
        do_reset();
        bus.ch_enable = 4'b1011;
        bus.run       = 1'b1;
        n = 0; b2b = 0; prev_rv = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (bus.result_valid) begin
                if (prev_rv) b2b++;
                if (n < 6) begin
                    ch_q[n]  = int'(bus.result_ch);
                    cyc_q[n] = c;
                end
                n++;
            end
            prev_rv = bus.result_valid;
            step(1);
        end
        checks++;
        if (n != 6) begin failures++; $display("FAIL rr_count: got %0d expected 6", n); end
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                checks++;
                if (ch_q[i] != exp_ch[i]) begin
                    failures++;
                    $display("FAIL rr_ch[%0d]: got %0d expected %0d", i, ch_q[i], exp_ch[i]);
                end
            end
        end
        for (int i = 1; i < 6; i++) begin
            if (i < n) begin
                checks++;
                if (cyc_q[i] - cyc_q[i-1] != 106) begin
                    failures++;
                    $display("FAIL rr_period[%0d]: got %0d expected 106", i, cyc_q[i] - cyc_q[i-1]);
                end
            end
        end
        checks++;
        if (b2b != 0) begin failures++; $display("FAIL rr_back_to_back: got %0d expected 0", b2b); end
        checks++;
        if (bus.result_count !== 16'd0) begin
            failures++;
            $display("FAIL rr_zero_count: got %0d expected 0", bus.result_count);
        end
    endtask

    task automatic test_counter_handshake();
        bit ok;
        int clr_n;
        int rv_k;
        logic p;
        do_reset();
        bus.ch_enable = 4'b0100;
        bus.run       = 1'b1;
        wait_for(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL hs_clear_timeout: got 0 expected 1"); end
        clr_n = 0;
        rv_k  = -1;
        // k = 0 is the cnt_clear cycle; gate spans k = S .. S+W-1.
        for (int k = 0; k < 130; k++) begin
            if (bus.cnt_clear) clr_n++;
            if (k == int'(S) - 1) begin
                checks++;
                if (bus.cnt_gate !== 1'b0) begin failures++; $display("FAIL hs_gate_early: got 1 expected 0"); end
            end
            if (k == int'(S)) begin
                checks++;
                if (bus.cnt_gate !== 1'b1) begin failures++; $display("FAIL hs_gate_rise: got 0 expected 1"); end
            end
            if (k == int'(S + W)) begin
                checks++;
                if (bus.cnt_gate !== 1'b0) begin failures++; $display("FAIL hs_gate_fall: got 1 expected 0"); end
            end
            if (bus.result_valid) begin rv_k = k; break; end
            p = 1'b0;
            if (k < int'(S) && (k % 2 == 0)) p = 1'b1;
            if (k >= 10 && k < 30 && (k % 2 == 0)) p = 1'b1;
            bus.pulse_in[2] = p;
            step(1);
        end
        bus.pulse_in = '0;
        checks++;
        if (rv_k != int'(S + W) + 1) begin
            failures++;
            $display("FAIL hs_result_time: got %0d expected %0d", rv_k, S + W + 1);
        end
        checks++;
        if (clr_n != 1) begin failures++; $display("FAIL hs_clear_once: got %0d expected 1", clr_n); end
        checks++;
        if (bus.result_ch !== 2'd2) begin
            failures++;
            $display("FAIL hs_result_ch: got %0d expected 2", bus.result_ch);
        end
        checks++;
        if (bus.result_count !== 16'd10) begin
            failures++;
            $display("FAIL hs_result_count: got %0d expected 10", bus.result_count);
        end
    endtask

    task automatic test_no_channels();
        do_reset();
        bus.ch_enable = '0;
        bus.run       = 1'b1;
        step(10);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL nc_busy: got %b expected 1", bus.busy); end
        checks++;
        if (bus.cnt_gate !== 1'b0 || bus.cnt_clear !== 1'b0) begin
            failures++;
            $display("FAIL nc_idle_counter: got gate=%b clear=%b expected 0/0", bus.cnt_gate, bus.cnt_clear);
        end
        bus.ch_enable = 4'b0010;
        step(1);
        checks++;
        if (bus.ch_sel !== 2'd1) begin failures++; $display("FAIL nc_ch_sel: got %0d expected 1", bus.ch_sel); end
        checks++;
        if (bus.cnt_clear !== 1'b1) begin failures++; $display("FAIL nc_clear: got %b expected 1", bus.cnt_clear); end
    endtask

    task automatic test_run_drop();
        bit ok;
        int extra;
        do_reset();
        bus.ch_enable = 4'b0001;
        bus.run       = 1'b1;
        wait_for(0, 50, ok);
        step(20);
        bus.run = 1'b0;
        wait_for(2, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rd_result_timeout: got 0 expected 1"); end
        step(1);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rd_busy_drop: got %b expected 0", bus.busy); end
        extra = 0;
        for (int i = 0; i < 250; i++) begin
            if (bus.result_valid || bus.cnt_gate) extra++;
            step(1);
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL rd_quiet_after: got %0d expected 0", extra); end
    endtask

    task automatic test_saturation();
        bit ok;
        do_reset();
        sat_force     = 1'b1;
        bus.ch_enable = 4'b0001;
        bus.run       = 1'b1;
        wait_for(2, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL sat_timeout1: got 0 expected 1"); end
        checks++;
        if (bus.result_sat !== 1'b1) begin failures++; $display("FAIL sat_flag: got %b expected 1", bus.result_sat); end
        checks++;
        if (bus.result_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_count: got %h expected ffff", bus.result_count);
        end
        sat_force = 1'b0;
        step(5);
        checks++;
        if (bus.result_count !== 16'hFFFF || bus.result_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: got %h/%b expected ffff/1", bus.result_count, bus.result_sat);
        end
        wait_for(2, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL sat_timeout2: got 0 expected 1"); end
        checks++;
        if (bus.result_sat !== 1'b0 || bus.result_count !== 16'd0) begin
            failures++;
            $display("FAIL sat_clear: got %b/%h expected 0/0000", bus.result_sat, bus.result_count);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_gate();
        test_round_robin();
        test_counter_handshake();
        test_no_channels();
        test_run_drop();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
